// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the mux4 round-robin arbiter: state encodings,
// index type and a one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int unsigned ArbN = 4;

    typedef logic [1:0] idx_t;

    localparam logic [1:0] StIdle    = 2'b00;
    localparam logic [1:0] StGranted = 2'b01;

    function automatic logic [ArbN-1:0] onehot4(input idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus of the mux4 arbiter: level requests and done in,
// registered grant and mux selects out.
interface mux4_rr_arbiter_if;

    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       sel1;
    logic       sel2;
    logic       busy;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel1,
        input  sel2,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel1,
        output sel2,
        output busy
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_prio_enc4.sv
// Rotating priority encoder: first set bit of req (optionally with one index
// masked off), scanning ptr, ptr+1, ... mod 4.
module rr_prio_enc4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  idx_t       ptr,
    input  logic       mask_en,
    input  idx_t       mask_idx,
    output logic       any,
    output idx_t       win
);

    logic [3:0] masked;

    always_comb begin
        masked = req & ~(mask_en ? onehot4(mask_idx) : 4'b0000);
        any    = |masked;
        win    = ptr;
        // Scan from the far end so the candidate closest to ptr is written last.
        for (int i = 3; i >= 0; i--) begin
            if (masked[ptr + 2'(i)]) begin
                win = ptr + 2'(i);
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; grant is held
// until release, done or the hold limit, with direct handoff between owners.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_LIMIT = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    mux4_rr_arbiter_if.slave         bus
);

    logic [1:0]       state_q, state_d;
    idx_t             ptr_q, ptr_d;
    idx_t             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;

    logic granted;
    logic hold_hit;
    logic release_now;
    logic enc_any;
    idx_t enc_ptr;
    idx_t enc_win;

    assign granted     = (state_q == StGranted);
    assign hold_hit    = (HOLD_LIMIT != 0) && (cnt_q == CNT_W'(HOLD_LIMIT));
    assign release_now = !bus.req[owner_q] || bus.done || hold_hit;
    // While granted, arbitrate from the post-release pointer with the owner masked off.
    assign enc_ptr     = granted ? owner_q + 2'd1 : ptr_q;

    rr_prio_enc4 u_prio_enc (
        .req      (bus.req),
        .ptr      (enc_ptr),
        .mask_en  (granted),
        .mask_idx (owner_q),
        .any      (enc_any),
        .win      (enc_win)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        case (state_q)
            StGranted: begin
                if (!release_now) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    ptr_d = enc_ptr;
                    if (enc_any) begin
                        owner_d = enc_win;
                        grant_d = onehot4(enc_win);
                        cnt_d   = CNT_W'(1);
                    end else if (bus.req[owner_q]) begin
                        // Owner is the only requester left: new tenure for it.
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                if (enc_any) begin
                    state_d = StGranted;
                    owner_d = enc_win;
                    grant_d = onehot4(enc_win);
                    cnt_d   = CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // sel follows the last owner, so it stays put while idle.
    assign bus.grant = grant_q;
    assign bus.sel1  = owner_q[0];
    assign bus.sel2  = owner_q[1];
    assign bus.busy  = |grant_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed + random bench for mux4_rr_arbiter against a behavioural model of
// owner, rotation pointer and tenure length.
module tb_mux4_rr_arbiter;

    localparam int unsigned HL = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus_if ();

    mux4_rr_arbiter #(
        .HOLD_LIMIT (HL),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner = -1 when idle; ten = cycles the current tenure has lasted.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_ten   = 0;
    int m_sel   = 0;

    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d, input logic rst);
        int w;
        bit rel;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_ten = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            w = first_from(m_ptr, r);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_ten = 1;
            end
        end else begin
            rel = !r[m_owner] || d || (HL != 0 && m_ten >= int'(HL));
            if (!rel) begin
                m_ten++;
            end else begin
                m_ptr = (m_owner + 1) % 4;
                w = first_from(m_ptr, r);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_ten = 1;
                end else begin
                    m_owner = -1; m_ten = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic rst);
        logic [3:0] exp_grant;
        logic [3:0] gidx;
        @(negedge clk);
        bus_if.req  = r;
        bus_if.done = d;
        reset       = rst;
        @(posedge clk);
        model_step(r, d, rst);
        #1;
        exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("grant", bus_if.grant, exp_grant);
        chk("sel", {2'b00, bus_if.sel2, bus_if.sel1}, 4'(m_sel));
        chk("busy", {3'b000, bus_if.busy}, {3'b000, m_owner >= 0});
        chk("onehot0", {3'b000, $onehot0(bus_if.grant)}, 4'b0001);
        chk("busy_or", {3'b000, bus_if.busy}, {3'b000, |bus_if.grant});
        if (bus_if.busy) begin
            gidx = 4'd0;
            for (int i = 0; i < 4; i++) if (bus_if.grant[i]) gidx = 4'(i);
            chk("sel_idx", {2'b00, bus_if.sel2, bus_if.sel1}, gidx);
        end
    endtask

    logic [3:0] rot [4];
    logic [3:0] rnd_req;

    initial begin
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b0;
        rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset held with all requests active.
        step(4'b1111, 1'b0, 1'b1);
        chk("rst_grant", bus_if.grant, 4'b0000);
        step(4'b1111, 1'b0, 1'b1);
        chk("rst_grant2", bus_if.grant, 4'b0000);
        chk("rst_sel", {2'b00, bus_if.sel2, bus_if.sel1}, 4'd0);

        // Single request and release.
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        chk("single_grant", bus_if.grant, 4'b0100);
        chk("single_sel", {2'b00, bus_if.sel2, bus_if.sel1}, 4'd2);
        step(4'b0000, 1'b0, 1'b0);
        chk("single_drop", bus_if.grant, 4'b0000);
        chk("single_sel_hold", {2'b00, bus_if.sel2, bus_if.sel1}, 4'd2);

        // Rotation with done each tenure.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("rot_first", bus_if.grant, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("rot_order", bus_if.grant, rot[i]);
            step(4'b1111, 1'b0, 1'b0);
            chk("rot_hold", bus_if.grant, rot[i]);
        end
        step(4'b0000, 1'b0, 1'b0);

        // Hold limit of 3 cycles.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 1'b0, 1'b0);
            chk("hold_r0", bus_if.grant, 4'b0001);
        end
        step(4'b0011, 1'b0, 1'b0);
        chk("hold_handoff", bus_if.grant, 4'b0010);
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'b0001, 1'b0, 1'b0);
            chk("hold_regrant", bus_if.grant, 4'b0001);
        end

        // Mid-tenure reset.
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        chk("mid_owner", bus_if.grant, 4'b1000);
        step(4'b1000, 1'b0, 1'b1);
        chk("mid_rst_grant", bus_if.grant, 4'b0000);
        chk("mid_rst_sel", {2'b00, bus_if.sel2, bus_if.sel1}, 4'd0);
        step(4'b1010, 1'b0, 1'b0);
        chk("mid_after", bus_if.grant, 4'b0010);

        // done while idle; simultaneous done and owner drop.
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("idle_done", bus_if.grant, 4'b0000);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0110, 1'b0, 1'b0);
        chk("sim_owner", bus_if.grant, 4'b0010);
        step(4'b0100, 1'b1, 1'b0);
        chk("sim_handoff", bus_if.grant, 4'b0100);
        step(4'b0100, 1'b0, 1'b0);
        chk("sim_single", bus_if.grant, 4'b0100);

        // Random traffic against the model.
        rnd_req = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) rnd_req = 4'($urandom_range(15));
            step(rnd_req, ($urandom_range(7) == 0), ($urandom_range(63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
